// File: rtl/hog_bank_wr_arbiter_if.sv
// Bank write-side bus for the HOG BRAM write arbiter: host pixel writes,
// engine result writes, the arbitrated BRAM port-A and FIFO status.
interface hog_bank_wr_arbiter_if #(
    parameter int NUM_BANKS = 4,
    parameter int RAM_AW    = 17,
    parameter int QN        = 10,
    parameter int P_WIDTH   = 8
);
    logic [NUM_BANKS-1:0]         host_wvalid;
    logic [NUM_BANKS-1:0]         host_wready;
    logic [NUM_BANKS*RAM_AW-1:0]  host_waddr;
    logic [NUM_BANKS*P_WIDTH-1:0] host_wdata;

    logic [NUM_BANKS-1:0]         eng_wen;
    logic [NUM_BANKS*RAM_AW-1:0]  eng_waddr;
    logic [NUM_BANKS*QN-1:0]      eng_wdata;

    logic [NUM_BANKS-1:0]         bram_en;
    logic [NUM_BANKS-1:0]         bram_we;
    logic [NUM_BANKS*RAM_AW-1:0]  bram_addr;
    logic [NUM_BANKS*QN-1:0]      bram_din;

    logic [NUM_BANKS-1:0]         fifo_empty;

    // Requester side: host and engine drive writes, observe the BRAM port.
    modport master (
        output host_wvalid, host_waddr, host_wdata,
        output eng_wen, eng_waddr, eng_wdata,
        input  host_wready, bram_en, bram_we, bram_addr, bram_din, fifo_empty
    );

    // Arbiter side.
    modport slave (
        input  host_wvalid, host_waddr, host_wdata,
        input  eng_wen, eng_waddr, eng_wdata,
        output host_wready, bram_en, bram_we, bram_addr, bram_din, fifo_empty
    );
endinterface

// File: rtl/hog_bank_wr_arbiter.sv
// Per-bank BRAM port-A write arbiter for the HOG engine. Each bank buffers
// host raw-pixel writes in a small FIFO; engine result writes always win the
// port and the stalled host cycles are counted. Also carries the registered
// pixel source mux (scaler / ramp / constant) feeding the HOG engine.
module hog_bank_wr_arbiter #(
    parameter int NUM_BANKS  = 4,
    parameter int RAM_AW     = 17,
    parameter int QN         = 10,
    parameter int P_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TEST_WRAP  = 32
) (
    input  logic                     aclk,
    input  logic                     rst,
    hog_bank_wr_arbiter_if.slave     bus,
    output logic [NUM_BANKS*16-1:0]  preempt_cnt,
    input  logic                     cnt_clr,
    input  logic [1:0]               test_mode,
    input  logic [P_WIDTH-1:0]       test_const,
    input  logic [P_WIDTH-1:0]       p_in,
    input  logic                     p_in_valid,
    input  logic                     finish,
    output logic [P_WIDTH-1:0]       p_out,
    output logic                     p_out_valid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = RAM_AW + P_WIDTH;
    localparam logic [P_WIDTH-1:0] RAMP_MAX = P_WIDTH'(TEST_WRAP - 1);

    // Saturating 16-bit increment for the preemption counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Zero-extend a host pixel to the BRAM word width.
    function automatic logic [QN-1:0] zext_pix(input logic [P_WIDTH-1:0] d);
        logic [QN-1:0] r;
        r = '0;
        r[P_WIDTH-1:0] = d;
        return r;
    endfunction

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : gen_bank
            logic [EW-1:0]     mem [FIFO_DEPTH];
            logic [PW:0]       wr_ptr;
            logic [PW:0]       wr_ptr_vis;
            logic [PW:0]       rd_ptr;
            logic              full;
            logic              empty;
            logic              avail;
            logic              push;
            logic              pop;
            logic              eng;
            logic [EW-1:0]     head;
            logic              en_p1;
            logic              we_p1;
            logic [RAM_AW-1:0] addr_p1;
            logic [QN-1:0]     din_p1;
            logic [15:0]       cnt_q;

            // Extra pointer bit separates full from empty when the low bits match.
            assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                           (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
            assign empty = (wr_ptr == rd_ptr);
            // An entry becomes eligible to pop one cycle after it lands, so a
            // push never bypasses the FIFO straight onto the BRAM port.
            assign avail = (wr_ptr_vis != rd_ptr);
            assign eng   = bus.eng_wen[b];
            assign push  = bus.host_wvalid[b] & ~full;
            assign pop   = ~eng & avail;
            assign head  = mem[rd_ptr[PW-1:0]];

            assign bus.host_wready[b]                = ~full;
            assign bus.fifo_empty[b]                 = empty;
            assign bus.bram_en[b]                    = en_p1;
            assign bus.bram_we[b]                    = we_p1;
            assign bus.bram_addr[b*RAM_AW +: RAM_AW] = addr_p1;
            assign bus.bram_din[b*QN +: QN]          = din_p1;
            assign preempt_cnt[b*16 +: 16]           = cnt_q;

            // FIFO storage: data only, no reset needed.
            always_ff @(posedge aclk) begin
                if (push) begin
                    mem[wr_ptr[PW-1:0]] <= {bus.host_waddr[b*RAM_AW +: RAM_AW],
                                            bus.host_wdata[b*P_WIDTH +: P_WIDTH]};
                end
            end

            // FIFO pointers; wr_ptr_vis trails wr_ptr by one cycle.
            always_ff @(posedge aclk or posedge rst) begin
                if (rst) begin
                    wr_ptr     <= '0;
                    wr_ptr_vis <= '0;
                    rd_ptr     <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    wr_ptr_vis <= wr_ptr;
                    if (pop) rd_ptr <= rd_ptr + 1'b1;
                end
            end

            // BRAM port-A register: engine first, then FIFO head, else idle.
            always_ff @(posedge aclk or posedge rst) begin
                if (rst) begin
                    en_p1   <= 1'b0;
                    we_p1   <= 1'b0;
                    addr_p1 <= '0;
                    din_p1  <= '0;
                end else if (eng) begin
                    en_p1   <= 1'b1;
                    we_p1   <= 1'b1;
                    addr_p1 <= bus.eng_waddr[b*RAM_AW +: RAM_AW];
                    din_p1  <= bus.eng_wdata[b*QN +: QN];
                end else if (pop) begin
                    en_p1   <= 1'b1;
                    we_p1   <= 1'b1;
                    addr_p1 <= head[EW-1:P_WIDTH];
                    din_p1  <= zext_pix(head[P_WIDTH-1:0]);
                end else begin
                    en_p1   <= 1'b0;
                    we_p1   <= 1'b0;
                end
            end

            // Preemption counter: host data waiting while the engine holds the port.
            always_ff @(posedge aclk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (cnt_clr) begin
                    cnt_q <= '0;
                end else if (eng && !empty) begin
                    cnt_q <= sat_inc16(cnt_q);
                end
            end
        end
    endgenerate

    logic [P_WIDTH-1:0] ramp_q;
    logic [P_WIDTH-1:0] pix_sel;
    logic [P_WIDTH-1:0] pix_p1;
    logic               vld_p1;

    // Ramp counter runs in every mode; finish restarts it.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            ramp_q <= '0;
        end else if (finish) begin
            ramp_q <= '0;
        end else if (p_in_valid) begin
            ramp_q <= (ramp_q == RAMP_MAX) ? '0 : ramp_q + 1'b1;
        end
    end

    // Pixel source select; ramp mode shows the pre-increment count.
    always_comb begin
        pix_sel = p_in;
        case (test_mode)
            2'b01:   pix_sel = ramp_q;
            2'b10:   pix_sel = test_const;
            default: pix_sel = p_in;
        endcase
    end

    // Pixel output register, one cycle behind the scaler.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            pix_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            pix_p1 <= pix_sel;
            vld_p1 <= p_in_valid;
        end
    end

    assign p_out       = pix_p1;
    assign p_out_valid = vld_p1;

endmodule
